// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor command path: command
// codes, ASCII characters recognised by the decoder, and decoder states.
package coproc_pkg;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_A    = 2'd1,
    CMD_S    = 2'd2,
    CMD_M    = 2'd3
  } cmd_t;

  typedef enum logic {
    RECEIVE = 1'b0,
    ISSUE   = 1'b1
  } state_t;

  localparam int unsigned ARRAY_W = 24;

  localparam logic [7:0] LF   = 8'h0A;
  localparam logic [7:0] CH_A = 8'h61;
  localparam logic [7:0] CH_S = 8'h73;
  localparam logic [7:0] CH_M = 8'h6D;

  // Map a command letter to its command code; any other byte means "no command".
  function automatic cmd_t decode_char(input logic [7:0] ch);
    cmd_t res;
    case (ch)
      CH_A:    res = CMD_A;
      CH_S:    res = CMD_S;
      CH_M:    res = CMD_M;
      default: res = CMD_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ascii_cmd_lut.sv
// Pure combinational lookup from an ASCII command letter to a command code.
module ascii_cmd_lut
  import coproc_pkg::*;
(
  input  logic [7:0] ch_i,
  output cmd_t       cmd_o
);

  // Translate the letter; unknown letters yield CMD_NONE so the line is dropped.
  always_comb begin
    cmd_o = decode_char(ch_i);
  end

endmodule

// File: rtl/coprocessor_command_decoder.sv
// Parses the UART RX byte stream into coprocessor commands. The last three
// non-LF bytes are kept in a shift register (newest in [7:0]); an LF decodes
// the newest byte into a one-cycle command strobe and clears the register.
// Bytes arriving while the coprocessor is busy are dropped.
module coprocessor_command_decoder
  import coproc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_received,
  input  logic                 rx_data_ready,
  input  logic                 coprocessor_busy,
  output logic [1:0]           command,
  output logic [1:0]           command_next,
  output logic [ARRAY_W-1:0]   array,
  output logic [ARRAY_W-1:0]   array_next
);

  state_t             state_q, state_d;
  cmd_t               command_q, command_d;
  logic [ARRAY_W-1:0] array_q, array_d;
  logic               accept_s;
  cmd_t               lut_cmd_s;

  // The command letter is always the newest byte in the shift register.
  ascii_cmd_lut u_lut (
    .ch_i  (array_q[7:0]),
    .cmd_o (lut_cmd_s)
  );

  // Next-state logic: accept/drop bytes, shift or decode on LF. ISSUE behaves
  // like RECEIVE for input handling so an LF arriving there is processed normally.
  always_comb begin
    accept_s  = rx_data_ready & ~coprocessor_busy;
    array_d   = array_q;
    command_d = CMD_NONE;
    state_d   = RECEIVE;
    case (state_q)
      RECEIVE, ISSUE: begin
        if (accept_s) begin
          if (byte_received == LF) begin
            command_d = lut_cmd_s;
            array_d   = {ARRAY_W{1'b0}};
            if (lut_cmd_s != CMD_NONE) begin
              state_d = ISSUE;
            end else begin
              state_d = RECEIVE;
            end
          end else begin
            array_d = {array_q[15:0], byte_received};
            state_d = RECEIVE;
          end
        end else begin
          array_d = array_q;
          state_d = RECEIVE;
        end
      end
      default: begin
        array_d   = {ARRAY_W{1'b0}};
        command_d = CMD_NONE;
        state_d   = RECEIVE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RECEIVE;
      command_q <= CMD_NONE;
      array_q   <= {ARRAY_W{1'b0}};
    end else begin
      state_q   <= state_d;
      command_q <= command_d;
      array_q   <= array_d;
    end
  end

  assign command      = command_q;
  assign command_next = command_d;
  assign array        = array_q;
  assign array_next   = array_d;

endmodule

// File: tb/tb_coprocessor_command_decoder.sv
// Self-checking bench: directed vector table for the documented scenarios,
// then randomized traffic against a queue-based reference model.
module tb_coprocessor_command_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_received = 8'h00;
  logic        rx_data_ready = 1'b0;
  logic        coprocessor_busy = 1'b0;
  logic [1:0]  command;
  logic [1:0]  command_next;
  logic [23:0] array;
  logic [23:0] array_next;

  int checks = 0;
  int failures = 0;

  coprocessor_command_decoder dut (
    .clk              (clk),
    .rst              (rst),
    .byte_received    (byte_received),
    .rx_data_ready    (rx_data_ready),
    .coprocessor_busy (coprocessor_busy),
    .command          (command),
    .command_next     (command_next),
    .array            (array),
    .array_next       (array_next)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        busy;
    logic [7:0]  b;
    logic [1:0]  cmd;
    logic [23:0] arr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; check next-value outputs before the edge, registers after it.
  task automatic cycle(input logic r, input logic rdy, input logic busy, input logic [7:0] b,
                       input logic [1:0] ecmd, input logic [23:0] earr, input string tag);
    @(negedge clk);
    rst = r;
    rx_data_ready = rdy;
    coprocessor_busy = busy;
    byte_received = b;
    #1;
    if (!r) begin
      chk({tag, "_command_next"}, {22'd0, command_next}, {22'd0, ecmd});
      chk({tag, "_array_next"}, array_next, earr);
    end
    @(posedge clk);
    #1;
    chk({tag, "_command"}, {22'd0, command}, {22'd0, ecmd});
    chk({tag, "_array"}, array, earr);
  endtask

  function automatic vec_t mk(input logic r, input logic rdy, input logic busy,
                              input logic [7:0] b, input logic [1:0] c, input logic [23:0] a);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.busy = busy; v.b = b; v.cmd = c; v.arr = a;
    return v;
  endfunction

  // Reference model: the accepted bytes of the current line, at most three kept.
  byte unsigned mq[$];

  function automatic logic [23:0] model_array();
    int unsigned v = 0;
    foreach (mq[i]) v = v * 256 + mq[i];
    return v[23:0];
  endfunction

  function automatic logic [1:0] letter_cmd(input byte unsigned ch);
    if (ch == 8'h61) return 2'd1;
    else if (ch == 8'h73) return 2'd2;
    else if (ch == 8'h6D) return 2'd3;
    else return 2'd0;
  endfunction

  initial begin
    // Reset and idle
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 24'h000000));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 24'h000000));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h41, 2'd0, 24'h000000));
    // "21ra" LF -> command 1 for one cycle
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h32, 2'd0, 24'h000032));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h31, 2'd0, 24'h003231));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h72, 2'd0, 24'h323172));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h61, 2'd0, 24'h317261));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0A, 2'd1, 24'h000000));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h0A, 2'd0, 24'h000000));
    // Busy drops '5'
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h35, 2'd0, 24'h000000));
    // "21ra2" with no LF
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h32, 2'd0, 24'h000032));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h31, 2'd0, 24'h003231));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h72, 2'd0, 24'h323172));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h61, 2'd0, 24'h317261));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h32, 2'd0, 24'h726132));
    // Busy LF with a full register is dropped too
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h0A, 2'd0, 24'h726132));
    // "12x" LF -> invalid, cleared
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h31, 2'd0, 24'h613231));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h32, 2'd0, 24'h323132));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h78, 2'd0, 24'h313278));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0A, 2'd0, 24'h000000));
    // 's' LF -> 2, 'm' LF -> 3
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h73, 2'd0, 24'h000073));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0A, 2'd2, 24'h000000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h6D, 2'd0, 24'h00006D));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0A, 2'd3, 24'h000000));
    // 'a' LF then LF while in ISSUE: register empty, so second strobe is 0
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h61, 2'd0, 24'h000061));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0A, 2'd1, 24'h000000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0A, 2'd0, 24'h000000));
    // rst after 'a' clears it; following LF yields no command
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h61, 2'd0, 24'h000061));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 24'h000000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0A, 2'd0, 24'h000000));
    // rst coinciding with an accepted LF after 'm' suppresses the strobe
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h6D, 2'd0, 24'h00006D));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h0A, 2'd0, 24'h000000));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 24'h000000));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].rdy, vecs[i].busy, vecs[i].b,
            vecs[i].cmd, vecs[i].arr, $sformatf("vec%0d", i));
    end

    // Randomized traffic against the reference model (DUT is in reset state here)
    mq.delete();
    for (int n = 0; n < 1500; n++) begin
      logic        r, rdy, busy;
      logic [7:0]  b;
      logic [1:0]  ecmd;
      int unsigned sel;
      r    = ($urandom_range(0, 63) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      busy = ($urandom_range(0, 3) == 0);
      sel  = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: b = 8'h0A;
        3:       b = 8'h61;
        4:       b = 8'h73;
        5:       b = 8'h6D;
        default: b = 8'($urandom_range(0, 255));
      endcase
      ecmd = 2'd0;
      if (r) begin
        mq.delete();
      end else if (rdy && !busy) begin
        if (b == 8'h0A) begin
          ecmd = (mq.size() > 0) ? letter_cmd(mq[mq.size()-1]) : 2'd0;
          mq.delete();
        end else begin
          mq.push_back(b);
          if (mq.size() > 3) void'(mq.pop_front());
        end
      end
      cycle(r, rdy, busy, b, ecmd, model_array(), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
